// File: rtl/butterfly_r2_pipe_if.sv
// Clock/reset bundle and valid/ready/last handshake bundle used by the radix-2 butterfly.
// The reset member keeps its legacy name rstn but is active-high.
interface butterfly_r2_pipe_clk_if;
   logic clk;
   logic rstn;
   modport sink (input clk, input rstn);
   modport source (output clk, output rstn);
endinterface

interface butterfly_r2_pipe_axis_if;
   logic tvalid;
   logic tready;
   logic tlast;
   modport master (output tvalid, output tlast, input tready);
   modport slave (input tvalid, input tlast, output tready);
endinterface

// File: rtl/butterfly_r2_pipe.sv
// Pipelined radix-2 DIT butterfly: y0 = x0 + x1*w, y1 = x0 - x1*w with optional conj(w),
// divide-by-2 with round-half-up, saturation and a sticky overflow flag; global-stall backpressure.
module butterfly_r2_pipe #(
   parameter int DW       = 9,
   parameter int TW       = 16,
   parameter int OW       = 10,
   parameter int MULT_LAT = 3
) (
   butterfly_r2_pipe_clk_if.sink     clk_rstn_i,
   butterfly_r2_pipe_axis_if.slave   s_axis,
   butterfly_r2_pipe_axis_if.master  m_axis,
   input  logic [1:0]                mode_i,
   input  logic [4*DW-1:0]           data_i,
   input  logic [2*TW-1:0]           twiddle_i,
   output logic [4*OW-1:0]           data_o,
   output logic                      ovf_o,
   input  logic                      clr_ovf_i
);
   localparam int PW = DW + TW;
   localparam int ML = MULT_LAT - 1;
   localparam int EW = (OW > DW + 3) ? OW : DW + 3;
   localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (OW - 1)) - 1);
   localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [PW:0]   RND_C   = (PW + 1)'(2 ** (TW - 2));

   // Round-half-up already added; keep the Q(TW-1) integer part (DW+2 bits).
   function automatic logic signed [DW+1:0] rnd_shift(input logic signed [PW:0] v);
      return v[PW:TW-1];
   endfunction

   // One output part: x0 +/- t, optional halving with round-half-up, clamp to OW bits.
   function automatic logic [OW:0] add_sat(input logic signed [DW-1:0] a,
                                           input logic signed [DW+1:0] t,
                                           input logic sub, input logic scl);
      logic signed [EW-1:0] ya, yt, y;
      ya = a;
      yt = t;
      if (sub) y = ya - yt;
      else     y = ya + yt;
      if (scl) begin
         y = y + EW'(1);
         y = y >>> 1;
      end
      if (y > SAT_MAX)      return {1'b1, SAT_MAX[OW-1:0]};
      else if (y < SAT_MIN) return {1'b1, SAT_MIN[OW-1:0]};
      else                  return {1'b0, y[OW-1:0]};
   endfunction

   logic clk, rst;
   assign clk = clk_rstn_i.clk;
   assign rst = clk_rstn_i.rstn;

   logic ce, rdy_en_r, a_vld_r, a_last_r, a_sat_r, ovf_r;
   logic [4*OW-1:0] data_r;
   assign ce            = ~a_vld_r | m_axis.tready;
   assign s_axis.tready = ce & rdy_en_r;
   assign m_axis.tvalid = a_vld_r;
   assign m_axis.tlast  = a_last_r;
   assign data_o        = data_r;
   assign ovf_o         = ovf_r;

   logic signed [DW-1:0] x0r_s, x0i_s, x1r_s, x1i_s;
   logic signed [TW-1:0] wr_s, wi_s;
   logic signed [TW:0]   wi_ext_s, wi_eff_s;
   assign x0r_s    = data_i[4*DW-1:3*DW];
   assign x0i_s    = data_i[3*DW-1:2*DW];
   assign x1r_s    = data_i[2*DW-1:DW];
   assign x1i_s    = data_i[DW-1:0];
   assign wr_s     = twiddle_i[2*TW-1:TW];
   assign wi_s     = twiddle_i[TW-1:0];
   assign wi_ext_s = wi_s;

   // Conjugate twiddle in inverse mode; the extra bit makes -(-1.0) exact.
   always_comb begin
      wi_eff_s = wi_ext_s;
      if (mode_i[0]) wi_eff_s = -wi_ext_s;
      else           wi_eff_s = wi_ext_s;
   end

   logic signed [PW-1:0] prr_s, pii_s, pri_s, pir_s;
   assign prr_s = PW'(x1r_s) * PW'(wr_s);
   assign pii_s = PW'(x1i_s) * PW'(wi_eff_s);
   assign pri_s = PW'(x1r_s) * PW'(wi_eff_s);
   assign pir_s = PW'(x1i_s) * PW'(wr_s);

   logic signed [PW-1:0] m_prr_r [MULT_LAT];
   logic signed [PW-1:0] m_pii_r [MULT_LAT];
   logic signed [PW-1:0] m_pri_r [MULT_LAT];
   logic signed [PW-1:0] m_pir_r [MULT_LAT];
   logic signed [DW-1:0] m_x0r_r [MULT_LAT];
   logic signed [DW-1:0] m_x0i_r [MULT_LAT];
   logic                 m_scl_r [MULT_LAT];
   logic                 m_last_r [MULT_LAT];
   logic                 m_vld_r [MULT_LAT];

   // Ready enable: tready stays low until the first clock after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_en_r <= 1'b0;
      else     rdy_en_r <= 1'b1;
   end

   // Multiply stage delay line (maps onto the DSP pipeline registers).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MULT_LAT; i++) begin
            m_prr_r[i]  <= '0;
            m_pii_r[i]  <= '0;
            m_pri_r[i]  <= '0;
            m_pir_r[i]  <= '0;
            m_x0r_r[i]  <= '0;
            m_x0i_r[i]  <= '0;
            m_scl_r[i]  <= 1'b0;
            m_last_r[i] <= 1'b0;
            m_vld_r[i]  <= 1'b0;
         end
      end else if (ce) begin
         m_prr_r[0]  <= prr_s;
         m_pii_r[0]  <= pii_s;
         m_pri_r[0]  <= pri_s;
         m_pir_r[0]  <= pir_s;
         m_x0r_r[0]  <= x0r_s;
         m_x0i_r[0]  <= x0i_s;
         m_scl_r[0]  <= mode_i[1];
         m_last_r[0] <= s_axis.tlast;
         m_vld_r[0]  <= s_axis.tvalid & rdy_en_r;
         for (int i = 1; i < MULT_LAT; i++) begin
            m_prr_r[i]  <= m_prr_r[i-1];
            m_pii_r[i]  <= m_pii_r[i-1];
            m_pri_r[i]  <= m_pri_r[i-1];
            m_pir_r[i]  <= m_pir_r[i-1];
            m_x0r_r[i]  <= m_x0r_r[i-1];
            m_x0i_r[i]  <= m_x0i_r[i-1];
            m_scl_r[i]  <= m_scl_r[i-1];
            m_last_r[i] <= m_last_r[i-1];
            m_vld_r[i]  <= m_vld_r[i-1];
         end
      end
   end

   logic signed [PW:0] tr_s, ti_s;
   assign tr_s = (PW + 1)'(m_prr_r[ML]) - (PW + 1)'(m_pii_r[ML]) + RND_C;
   assign ti_s = (PW + 1)'(m_pri_r[ML]) + (PW + 1)'(m_pir_r[ML]) + RND_C;

   logic signed [DW+1:0] r_tr_r, r_ti_r;
   logic signed [DW-1:0] r_x0r_r, r_x0i_r;
   logic                 r_scl_r, r_last_r, r_vld_r;

   // Rounding stage: complex product t rounded back to data scale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tr_r   <= '0;
         r_ti_r   <= '0;
         r_x0r_r  <= '0;
         r_x0i_r  <= '0;
         r_scl_r  <= 1'b0;
         r_last_r <= 1'b0;
         r_vld_r  <= 1'b0;
      end else if (ce) begin
         r_tr_r   <= rnd_shift(tr_s);
         r_ti_r   <= rnd_shift(ti_s);
         r_x0r_r  <= m_x0r_r[ML];
         r_x0i_r  <= m_x0i_r[ML];
         r_scl_r  <= m_scl_r[ML];
         r_last_r <= m_last_r[ML];
         r_vld_r  <= m_vld_r[ML];
      end
   end

   logic [OW:0] y0r_s, y0i_s, y1r_s, y1i_s;
   assign y0r_s = add_sat(r_x0r_r, r_tr_r, 1'b0, r_scl_r);
   assign y0i_s = add_sat(r_x0i_r, r_ti_r, 1'b0, r_scl_r);
   assign y1r_s = add_sat(r_x0r_r, r_tr_r, 1'b1, r_scl_r);
   assign y1i_s = add_sat(r_x0i_r, r_ti_r, 1'b1, r_scl_r);

   // Add/subtract stage and output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r   <= '0;
         a_sat_r  <= 1'b0;
         a_vld_r  <= 1'b0;
         a_last_r <= 1'b0;
      end else if (ce) begin
         data_r   <= {y0r_s[OW-1:0], y0i_s[OW-1:0], y1r_s[OW-1:0], y1i_s[OW-1:0]};
         a_sat_r  <= y0r_s[OW] | y0i_s[OW] | y1r_s[OW] | y1i_s[OW];
         a_vld_r  <= r_vld_r;
         a_last_r <= r_last_r;
      end
   end

   // Sticky overflow: only beats actually handed downstream count; set beats clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         ovf_r <= 1'b0;
      else if (a_vld_r & m_axis.tready & a_sat_r)      ovf_r <= 1'b1;
      else if (clr_ovf_i)                              ovf_r <= 1'b0;
      else                                             ovf_r <= ovf_r;
   end
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Self-checking bench for butterfly_r2_pipe: directed vector table, sticky-flag sequences,
// backpressure stream against an integer model, and reset with beats in flight.
module tb_butterfly_r2_pipe;
   localparam int DW = 9;
   localparam int TW = 16;
   localparam int OW = 10;
   localparam int MULT_LAT = 3;

   butterfly_r2_pipe_clk_if  cr();
   butterfly_r2_pipe_axis_if s_if();
   butterfly_r2_pipe_axis_if m_if();

   logic [1:0]       mode;
   logic [4*DW-1:0]  din;
   logic [2*TW-1:0]  tw;
   logic [4*OW-1:0]  dout;
   logic             ovf;
   logic             clr;

   int checks = 0;
   int errors = 0;

   butterfly_r2_pipe #(.DW(DW), .TW(TW), .OW(OW), .MULT_LAT(MULT_LAT)) dut (
      .clk_rstn_i (cr),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .mode_i     (mode),
      .data_i     (din),
      .twiddle_i  (tw),
      .data_o     (dout),
      .ovf_o      (ovf),
      .clr_ovf_i  (clr)
   );

   initial cr.clk = 1'b0;
   always #5 cr.clk = ~cr.clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0] mode;
      int x0r, x0i, x1r, x1i, wr, wi;
      int y0r, y0i, y1r, y1i;
      logic ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int fld(input logic [4*OW-1:0] d, input int k);
      logic signed [OW-1:0] v;
      v = d[(3-k)*OW +: OW];
      return int'(v);
   endfunction

   // Integer reference of the butterfly arithmetic.
   task automatic model(input int x0r, input int x0i, input int x1r, input int x1i,
                        input int wr, input int wi, input logic [1:0] md,
                        output logic [4*OW-1:0] d, output logic sat);
      int wie, tr, ti, t_r, t_i;
      int y[4];
      wie = md[0] ? -wi : wi;
      tr  = x1r * wr - x1i * wie;
      ti  = x1r * wie + x1i * wr;
      t_r = (tr + (1 << (TW - 2))) >>> (TW - 1);
      t_i = (ti + (1 << (TW - 2))) >>> (TW - 1);
      y[0] = x0r + t_r;
      y[1] = x0i + t_i;
      y[2] = x0r - t_r;
      y[3] = x0i - t_i;
      sat = 1'b0;
      d = '0;
      for (int k = 0; k < 4; k++) begin
         if (md[1]) y[k] = (y[k] + 1) >>> 1;
         if (y[k] > 511) begin y[k] = 511; sat = 1'b1; end
         else if (y[k] < -512) begin y[k] = -512; sat = 1'b1; end
         d[(3-k)*OW +: OW] = OW'(y[k]);
      end
   endtask

   task automatic drive(input logic [1:0] md, input int x0r, input int x0i, input int x1r,
                        input int x1i, input int wr, input int wi);
      mode = md;
      din  = {DW'(x0r), DW'(x0i), DW'(x1r), DW'(x1i)};
      tw   = {TW'(wr), TW'(wi)};
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      clr = 1'b1;
      @(posedge cr.clk); #1;
      clr = 1'b0;
      drive(v.mode, v.x0r, v.x0i, v.x1r, v.x1i, v.wr, v.wi);
      s_if.tvalid = 1'b1;
      s_if.tlast  = 1'b1;
      m_if.tready = 1'b1;
      #1;
      chk({tag, "_in_ready"}, s_if.tready, 1);
      @(posedge cr.clk); #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      lat = 1;
      while (!m_if.tvalid && lat < 20) begin
         @(posedge cr.clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, MULT_LAT + 2);
      chk({tag, "_y0r"}, fld(dout, 0), v.y0r);
      chk({tag, "_y0i"}, fld(dout, 1), v.y0i);
      chk({tag, "_y1r"}, fld(dout, 2), v.y1r);
      chk({tag, "_y1i"}, fld(dout, 3), v.y1i);
      chk({tag, "_tlast"}, m_if.tlast, 1);
      @(posedge cr.clk); #1;
      chk({tag, "_ovf"}, ovf, v.ovf);
      chk({tag, "_drained"}, m_if.tvalid, 0);
   endtask

   int bp_x[16][4];
   int bp_w[16][2];
   logic [1:0] bp_m[16];
   logic [4*OW-1:0] exp_q[$];
   logic [4*OW-1:0] e_d, prev_d;
   logic e_sat, prev_hold, stall_seen, s_fire, m_fire;
   int sent, rcvd, cyc, n, seen;

   initial begin
      vecs[0] = '{2'b00, 100, 0, 40, 20, 16384, 0, 120, 10, 80, -10, 1'b0};
      vecs[1] = '{2'b00, 100, 0, 41, 0, 16384, 0, 121, 0, 79, 0, 1'b0};
      vecs[2] = '{2'b10, 100, 0, 41, 0, 16384, 0, 61, 0, 40, 0, 1'b0};
      vecs[3] = '{2'b00, 0, 0, 40, 20, 0, 16384, -10, 20, 10, -20, 1'b0};
      vecs[4] = '{2'b01, 0, 0, 40, 20, 0, 16384, 10, -20, -10, 20, 1'b0};
      vecs[5] = '{2'b00, 255, 255, 255, 255, 23170, 23170, 255, 511, 255, -106, 1'b1};
      vecs[6] = '{2'b00, 0, 0, 100, -50, -32768, 0, -100, 50, 100, -50, 1'b0};
      vecs[7] = '{2'b01, -256, 0, -256, -256, -32768, -32768, 256, 0, -512, 0, 1'b1};
      vecs[8] = '{2'b11, -256, 0, -256, -256, -32768, -32768, 128, 0, -384, 0, 1'b0};
      vecs[9] = '{2'b11, 0, 0, 40, 20, 0, 16384, 5, -10, -5, 10, 1'b0};

      cr.rstn = 1'b1;
      clr = 1'b0;
      mode = '0;
      din = '0;
      tw = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      m_if.tready = 1'b1;

      // Reset state.
      repeat (3) @(posedge cr.clk);
      #1;
      chk("rst_in_ready", s_if.tready, 0);
      chk("rst_out_valid", m_if.tvalid, 0);
      chk("rst_out_last", m_if.tlast, 0);
      chk("rst_data", dout, 0);
      chk("rst_ovf", ovf, 0);
      cr.rstn = 1'b0;
      #1;
      chk("rel_ready_low", s_if.tready, 0);
      @(posedge cr.clk); #1;
      chk("rel_ready_high", s_if.tready, 1);

      // Directed table.
      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Sticky flag, clear, and set-wins-over-clear.
      run_vec(vecs[5], "sticky");
      repeat (3) @(posedge cr.clk);
      #1;
      chk("ovf_sticky", ovf, 1);
      clr = 1'b1;
      @(posedge cr.clk); #1;
      clr = 1'b0;
      chk("ovf_cleared", ovf, 0);
      drive(vecs[5].mode, vecs[5].x0r, vecs[5].x0i, vecs[5].x1r, vecs[5].x1i, vecs[5].wr, vecs[5].wi);
      s_if.tvalid = 1'b1;
      clr = 1'b1;
      @(posedge cr.clk); #1;
      s_if.tvalid = 1'b0;
      n = 0;
      while (!m_if.tvalid && n < 20) begin
         @(posedge cr.clk); #1;
         n++;
      end
      chk("sw_out_valid", m_if.tvalid, 1);
      @(posedge cr.clk); #1;
      chk("ovf_set_wins", ovf, 1);
      clr = 1'b0;

      // Backpressure stream of 16 beats.
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 4; k++) bp_x[i][k] = int'($urandom_range(0, 511)) - 256;
         bp_w[i][0] = int'($urandom_range(0, 65535)) - 32768;
         bp_w[i][1] = int'($urandom_range(0, 65535)) - 32768;
         bp_m[i] = 2'($urandom_range(0, 3));
      end
      sent = 0;
      rcvd = 0;
      cyc = 0;
      prev_hold = 1'b0;
      stall_seen = 1'b0;
      prev_d = '0;
      while (rcvd < 16 && cyc < 400) begin
         if (sent < 16) begin
            drive(bp_m[sent], bp_x[sent][0], bp_x[sent][1], bp_x[sent][2], bp_x[sent][3],
                  bp_w[sent][0], bp_w[sent][1]);
            s_if.tvalid = 1'b1;
            s_if.tlast = (sent == 15);
         end else begin
            s_if.tvalid = 1'b0;
            s_if.tlast = 1'b0;
         end
         if (cyc < 3)        m_if.tready = 1'b1;
         else if (cyc <= 12) m_if.tready = 1'b0;
         else                m_if.tready = 1'($urandom_range(0, 1));
         #1;
         if (prev_hold) chk("bp_hold_stable", dout, prev_d);
         if (!stall_seen && s_if.tvalid && !s_if.tready) begin
            stall_seen = 1'b1;
            chk("bp_fill_depth", sent - rcvd, MULT_LAT + 2);
         end
         s_fire = s_if.tvalid & s_if.tready;
         m_fire = m_if.tvalid & m_if.tready;
         if (m_fire) begin
            if (exp_q.size() == 0) begin
               chk("bp_unexpected_beat", rcvd, -1);
            end else begin
               chk($sformatf("bp_beat%0d", rcvd), dout, exp_q[0]);
               void'(exp_q.pop_front());
            end
            chk($sformatf("bp_last%0d", rcvd), m_if.tlast, rcvd == 15);
            rcvd++;
         end
         if (s_fire) begin
            model(bp_x[sent][0], bp_x[sent][1], bp_x[sent][2], bp_x[sent][3],
                  bp_w[sent][0], bp_w[sent][1], bp_m[sent], e_d, e_sat);
            exp_q.push_back(e_d);
            sent++;
         end
         prev_hold = m_if.tvalid & ~m_if.tready;
         prev_d = dout;
         @(posedge cr.clk); #1;
         cyc++;
      end
      chk("bp_beats_out", rcvd, 16);
      chk("bp_stall_seen", stall_seen, 1);

      // Reset with three beats in flight.
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      m_if.tready = 1'b1;
      repeat (8) @(posedge cr.clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         drive(vecs[1].mode, vecs[1].x0r, vecs[1].x0i, vecs[1].x1r, vecs[1].x1i, vecs[1].wr, vecs[1].wi);
         s_if.tvalid = 1'b1;
         @(posedge cr.clk); #1;
      end
      s_if.tvalid = 1'b0;
      cr.rstn = 1'b1;
      #1;
      chk("mid_rst_valid", m_if.tvalid, 0);
      chk("mid_rst_data", dout, 0);
      chk("mid_rst_ready", s_if.tready, 0);
      chk("mid_rst_ovf", ovf, 0);
      repeat (2) @(posedge cr.clk);
      #1;
      cr.rstn = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge cr.clk); #1;
         if (m_if.tvalid) seen++;
      end
      chk("mid_rst_no_stale", seen, 0);
      run_vec(vecs[0], "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
